// File: rtl/y_fetch_seq_if.sv
// Fetch-stage bus bundle: the instruction-memory request/acknowledge channel
// and the downstream instruction valid/ready channel.
//   imem_req   : fetch request (driven by fetch stage)
//   imem_addr  : fetch address (driven by fetch stage)
//   imem_ack   : memory returns data this cycle (driven by memory)
//   imem_rdata : instruction word, valid with imem_ack (driven by memory)
//   ins_valid  : ins holds a fetched instruction (driven by fetch stage)
//   ins        : fetched instruction (driven by fetch stage)
//   ins_ready  : downstream accepts ins this cycle (driven by consumer)
// master = fetch stage side, slave = memory/consumer side.
interface y_fetch_seq_if #(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [ILEN-1:0]  imem_rdata;
  logic             ins_valid;
  logic [ILEN-1:0]  ins;
  logic             ins_ready;

  modport master (
    output imem_req, imem_addr, ins_valid, ins,
    input  imem_ack, imem_rdata, ins_ready
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins,
    output imem_ack, imem_rdata, ins_ready
  );
endinterface

// File: rtl/y_fetch_seq.sv
// Sequential instruction-fetch stage. Holds the PC, runs a req/ack handshake
// to instruction memory and presents the fetched word downstream with
// valid/ready. Supports branch/jump redirect and halt.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   bus (master)     : imem_req/imem_addr/imem_ack/imem_rdata and
//                      ins_valid/ins/ins_ready
//   pc, pc_plus4     : current PC and PC+4 (combinational, wraps)
//   redirect         : load redirect_target (low 2 bits forced to 0)
//   halt             : stop fetching after the current instruction
module y_fetch_seq #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int               ILEN     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  y_fetch_seq_if.master    bus,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             halt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [ILEN-1:0]  ins_q, ins_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] pc_inc_s;

  // Word-aligned redirect target and sequential next PC (wraps naturally).
  always_comb begin
    target_s = redirect_target & ALIGN_MASK;
    pc_inc_s = pc_q + PC_STEP;
  end

  // Next-state, next-PC and instruction-capture logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    case (state_q)
      // Single bubble after reset; redirect is deliberately ignored here.
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          // Any same-cycle ack is discarded: ins is not updated.
          pc_d    = target_s;
          state_d = halt ? ST_HALTED : ST_REQ;
        end else if (bus.imem_ack) begin
          ins_d   = bus.imem_rdata;
          state_d = ST_HOLD;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          // Consumed or not, the redirect target wins over pc+4.
          pc_d    = target_s;
          state_d = halt ? ST_HALTED : ST_REQ;
        end else if (bus.ins_ready) begin
          pc_d    = pc_inc_s;
          state_d = halt ? ST_HALTED : ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        if (redirect) begin
          pc_d    = target_s;
          state_d = halt ? ST_HALTED : ST_REQ;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they are pure Moore.
    req_d   = (state_d == ST_REQ);
    valid_d = (state_d == ST_HOLD);
  end

  // State, PC, instruction and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      ins_q   <= {ILEN{1'b0}};
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.ins_valid = valid_q;
  assign bus.ins       = ins_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_inc_s;

endmodule

// File: doc/y_fetch_seq.md
Name: y_fetch_seq

Overview:
- Sequential instruction-fetch stage for the single-cycle datapath. It sits directly upstream of the next-PC 2:1 mux.
- Holds the PC register and runs a request/acknowledge handshake to instruction memory.
- Presents the fetched instruction downstream with valid/ready.
- Produces pc and pc_plus4, which feed the PC-select mux inputs. A taken branch or jump arrives back as redirect/redirect_target.

Parameters:
WIDTH, 32, PC and address width in bits
RESET_PC, 0, PC value loaded at reset; bits [1:0] must be 0
ILEN, 32, instruction word width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WIDTH  fetch address; equals pc
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  ILEN  instruction word, valid when imem_ack=1
ins_valid  output  1  ins holds a fetched instruction
ins  output  ILEN  fetched instruction (registered)
ins_ready  input  1  downstream accepts ins this cycle
pc  output  WIDTH  address of the current instruction
pc_plus4  output  WIDTH  pc+4, combinational, wraps modulo 2^WIDTH
redirect  input  1  load redirect_target into PC (branch/jump taken)
redirect_target  input  WIDTH  new PC; bits [1:0] are ignored and forced to 0
halt  input  1  stop fetching after the current instruction

Behaviour:
- Reset: rst_n=0 sampled at a clk edge gives:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, ins_valid=0, ins=0
  - Reset overrides all other inputs.
  - Reset mid-handshake drops any outstanding request; a late imem_ack is ignored.
- Outputs:
  - imem_req=1 exactly when state=REQ (Moore).
  - ins_valid=1 exactly when state=HOLD.
  - imem_addr=pc at all times.
- IDLE: one bubble cycle after reset, then unconditionally go to REQ.
- REQ:
  - pc and imem_addr stay stable until ack or redirect.
  - imem_ack=1: ins<=imem_rdata, go to HOLD. Fetch latency is one cycle from ack to ins_valid.
  - imem_ack=0 and halt=1: go to HALTED. imem_req drops next cycle.
  - imem_ack=1 wins over halt.
- HOLD:
  - ins and pc are held while ins_ready=0.
  - ins_ready=1: pc<=pc+4 with wrap (0xFFFFFFFC -> 0x00000000).
  - Next state after ins_ready=1 is HALTED if halt=1, else REQ.
  - Back-to-back throughput is therefore one instruction per 2 cycles minimum (REQ+ack, HOLD+ready).
- HALTED:
  - imem_req=0, ins_valid=0, pc frozen.
  - Exits only on redirect=1 with halt=0.
- redirect priority:
  - redirect has the highest priority in REQ, HOLD and HALTED.
  - Effect: pc<={redirect_target[WIDTH-1:2],2'b00}, go to REQ.
  - ins_valid drops next cycle. An imem_ack in the same cycle is discarded.
  - redirect in HOLD with ins_ready=1: the instruction counts as consumed, and redirect_target wins over pc+4.
  - redirect with halt=1 goes to HALTED with the pc loaded.
  - redirect in IDLE is ignored.
- State encoding is a 2-bit register with no illegal reachable states. Any unreached encoding recovers to IDLE.

Test Plan:
- Reset then run: rst_n=0 for 2 cycles with RESET_PC=0; memory acks every REQ cycle with rdata=0x00000013; ins_ready=1 -> imem_req first high 1 cycle after reset release; pc sequence 0,4,8; each ins_valid pulse shows 0x00000013.
- Memory stall: hold imem_ack=0 for 3 cycles in REQ at pc=0x10 -> imem_req=1 and imem_addr=0x10 stable all 3 cycles; ack with 0xDEADBEEF -> ins=0xDEADBEEF, ins_valid=1 next cycle.
- Downstream stall: HOLD with ins_ready=0 for 4 cycles -> ins and pc unchanged; ready=1 -> pc advances by exactly 4.
- Redirect: redirect=1 with target 0x103 in the same cycle as imem_ack -> data discarded; pc=0x100; next imem_addr=0x100; no ins_valid for the dropped word.
- Halt/resume: halt=1 during HOLD, then ready=1 -> HALTED; imem_req=0 with pc frozen for 5 cycles; redirect to 0x40 with halt=0 -> fetch resumes at 0x40.
- Wrap and mid-op reset: redirect to 0xFFFFFFFC and consume -> pc=0x00000000; rst_n=0 during REQ -> pc=RESET_PC, imem_req=0 next cycle; a late ack is ignored.
